// File: rtl/rv_fetch_unit.sv
// Instruction fetch front end: one-outstanding req/ack fetcher feeding a small
// prefetch FIFO, drained by the core over valid/ready, with redirect/flush.
module rv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        ResetPC,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] Instruction,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    // state | meaning
    // IDLE  | no request outstanding; issue one when the FIFO has room
    // WAIT  | request outstanding; its ack data will be pushed
    // DROP  | request outstanding but stale after a redirect; ack data is discarded

    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     pc_hold_q;
    logic [31:0]     inst_mem [DEPTH];
    logic [31:0]     pc_mem   [DEPTH];

    logic            push;
    logic            pop;
    logic            space;
    logic [31:0]     redirect_pc_al;

    assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;
    // In IDLE nothing is outstanding, so room in the FIFO alone guarantees the ack fits.
    assign space          = (count_q < CW'(DEPTH));
    assign pop            = inst_valid & inst_ready & ~redirect;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!redirect && space) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!redirect) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_pc_al;
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (ResetPC) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            pc_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pc_hold_q  <= inst_pc;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !ResetPC) begin
            inst_mem[wr_ptr_q] <= mem_rdata;
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign inst_valid  = (count_q != '0);
    // An empty FIFO shows a NOP but keeps the last PC the core saw.
    assign Instruction = inst_valid ? inst_mem[rd_ptr_q] : NOP;
    assign inst_pc     = inst_valid ? pc_mem[rd_ptr_q] : pc_hold_q;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: directed scenarios plus a randomized run, all checked
// against a stream-level model (expected next PC, occupancy, stale request).
module tb_rv_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        ResetPC;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] Instruction;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    rv_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .ResetPC     (ResetPC),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .Instruction (Instruction),
        .inst_pc     (inst_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // memory stub controls
    bit          auto_mem;
    int          max_lat;
    int          lat_left;
    bit          lat_armed;
    bit          use_const;
    logic [31:0] const_word;

    // reference model
    int          m_occ;
    int          m_pops;
    logic [31:0] m_fetch_pc;
    logic [31:0] m_exp_pc;
    logic [31:0] m_last_pc;
    bit          m_stale;
    logic [31:0] req_addrs [$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (use_const) return const_word;
        return (a ^ 32'hC0DE_0000) + 32'h0000_1111;
    endfunction

    task automatic model_init();
        m_occ      = 0;
        m_pops     = 0;
        m_fetch_pc = RESET_PC;
        m_exp_pc   = RESET_PC;
        m_last_pc  = 32'h0;
        m_stale    = 1'b0;
        lat_armed  = 1'b0;
        req_addrs.delete();
    endtask

    task automatic mem_drive();
        if (!auto_mem) return;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        if (mem_req) begin
            if (!lat_armed) begin
                lat_left  = $urandom_range(0, max_lat);
                lat_armed = 1'b1;
            end
            if (lat_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = word_of(mem_addr);
                lat_armed = 1'b0;
            end else begin
                lat_left--;
            end
        end else begin
            lat_armed = 1'b0;
        end
    endtask

    // One clock: apply inputs, step the model, check the outputs after the edge.
    task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
        logic        pre_req;
        logic [31:0] pre_addr;
        logic        ack;
        bit          push;
        bit          pop;
        mem_drive();
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        pre_req     = mem_req;
        pre_addr    = mem_addr;
        ack         = mem_ack;
        @(posedge CLK);
        #1;
        if (!auto_mem) mem_ack = 1'b0;
        push = ack && pre_req && !rd && !m_stale;
        pop  = (m_occ != 0) && rdy && !rd;
        if (rd) begin
            m_occ      = 0;
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
            m_exp_pc   = m_fetch_pc;
            m_stale    = pre_req && !ack;
        end else begin
            if (push) begin
                m_occ++;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (pop) begin
                m_occ--;
                m_pops++;
                m_exp_pc = m_exp_pc + 32'd4;
            end
            if (ack) m_stale = 1'b0;
        end

        checks++;
        if (inst_valid !== (m_occ != 0))
            begin errors++; $display("FAIL valid: got %b exp %b (occ %0d)", inst_valid, (m_occ != 0), m_occ); end
        if (m_occ != 0) begin
            checks++;
            if (inst_pc !== m_exp_pc || Instruction !== word_of(m_exp_pc))
                begin errors++; $display("FAIL head: got pc %h inst %h exp pc %h inst %h", inst_pc, Instruction, m_exp_pc, word_of(m_exp_pc)); end
            m_last_pc = m_exp_pc;
        end else begin
            checks++;
            if (Instruction !== NOP || inst_pc !== m_last_pc)
                begin errors++; $display("FAIL empty_head: got pc %h inst %h exp pc %h inst %h", inst_pc, Instruction, m_last_pc, NOP); end
        end
        if (mem_req === 1'b1 && !pre_req) begin
            req_addrs.push_back(mem_addr);
            checks++;
            if (mem_addr !== m_fetch_pc || m_occ >= DEPTH || rd)
                begin errors++; $display("FAIL issue: addr %h exp %h occ %0d redirect %b", mem_addr, m_fetch_pc, m_occ, rd); end
        end else if (pre_req) begin
            checks++;
            if (mem_req !== !ack || (mem_req && mem_addr !== pre_addr))
                begin errors++; $display("FAIL req_hold: req %b addr %h exp req %b addr %h", mem_req, mem_addr, !ack, pre_addr); end
        end
    endtask

    task automatic do_reset();
        ResetPC     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h1234_5678;
        mem_ack     = 1'b1;
        mem_rdata   = 32'hBAD0_0000;
        inst_ready  = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        ResetPC    = 1'b0;
        redirect   = 1'b0;
        mem_ack    = 1'b0;
        inst_ready = 1'b0;
        model_init();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", mem_req); end
        checks++;
        if (mem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr: got %h exp %h", mem_addr, RESET_PC); end
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", inst_valid); end
        checks++;
        if (Instruction !== NOP || inst_pc !== 32'h0)
            begin errors++; $display("FAIL rst_head: got %h/%h exp %h/0", Instruction, inst_pc, NOP); end
    endtask

    task automatic test_first_fetch_and_backpressure();
        do_reset();
        auto_mem = 1'b1; max_lat = 0; use_const = 1'b1; const_word = 32'h0031_80B3;
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0)
            begin errors++; $display("FAIL first_req: got %b/%h exp 1/0", mem_req, mem_addr); end
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b1 || Instruction !== 32'h0031_80B3 || inst_pc !== 32'h0)
            begin errors++; $display("FAIL first_inst: got %b %h %h exp 1 003180b3 0", inst_valid, Instruction, inst_pc); end
        repeat (12) cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (req_addrs.size() != 4 || req_addrs[0] !== 32'd0 || req_addrs[1] !== 32'd4 ||
            req_addrs[2] !== 32'd8 || req_addrs[3] !== 32'd12 || mem_req !== 1'b0)
            begin errors++; $display("FAIL backpressure: got %0d requests, req %b, exp 4 requests 0..12 then req 0", req_addrs.size(), mem_req); end
        cycle(1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_pc !== 32'd4) begin errors++; $display("FAIL bp_pop: got head %h exp 4", inst_pc); end
        repeat (8) cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (req_addrs.size() != 5 || req_addrs[req_addrs.size()-1] !== 32'd16 || mem_req !== 1'b0)
            begin errors++; $display("FAIL bp_refill: got %0d requests last %h exp 5 requests last 10", req_addrs.size(), req_addrs[req_addrs.size()-1]); end
        use_const = 1'b0;
    endtask

    task automatic test_redirect_idle();
        int          n;
        bit          seen;
        logic [31:0] first_pc;
        do_reset();
        auto_mem = 1'b0; use_const = 1'b0;
        cycle(1'b0, 1'b0, 32'h0);
        mem_ack = 1'b1; mem_rdata = word_of(32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        mem_ack = 1'b1; mem_rdata = word_of(32'h4);
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL ri_setup: got %b %h %b exp 1 0 0", inst_valid, inst_pc, mem_req); end
        n = req_addrs.size();
        cycle(1'b0, 1'b1, 32'h0000_0103);
        checks++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL ri_flush: got valid %b req %b exp 0 0", inst_valid, mem_req); end
        auto_mem = 1'b1; max_lat = 1;
        seen = 1'b0; first_pc = 32'h0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (inst_valid === 1'b1) begin first_pc = inst_pc; seen = 1'b1; end
            else cycle(1'b1, 1'b0, 32'h0);
        end
        checks++;
        if (req_addrs.size() <= n || req_addrs[n] !== 32'h100)
            begin errors++; $display("FAIL ri_addr: got %0d requests, exp next addr 100", req_addrs.size() - n); end
        checks++;
        if (!seen || first_pc !== 32'h100)
            begin errors++; $display("FAIL ri_first_pc: seen %b got %h exp 100", seen, first_pc); end
    endtask

    task automatic test_redirect_outstanding();
        bit seen;
        do_reset();
        auto_mem = 1'b0; use_const = 1'b0;
        cycle(1'b0, 1'b0, 32'h0);
        mem_ack = 1'b1; mem_rdata = word_of(32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        mem_ack = 1'b1; mem_rdata = word_of(32'h4);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8)
            begin errors++; $display("FAIL ro_pending: got %b/%h exp 1/8", mem_req, mem_addr); end
        cycle(1'b0, 1'b1, 32'h40);
        checks++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8)
            begin errors++; $display("FAIL ro_drop: got %b %b %h exp 0 1 8", inst_valid, mem_req, mem_addr); end
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b0)
            begin errors++; $display("FAIL ro_ack: got req %b valid %b exp 0 0", mem_req, inst_valid); end
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40)
            begin errors++; $display("FAIL ro_restart: got %b/%h exp 1/40", mem_req, mem_addr); end
        auto_mem = 1'b1; max_lat = 2;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (inst_valid === 1'b1) seen = 1'b1;
            else cycle(1'b1, 1'b0, 32'h0);
        end
        checks++;
        if (!seen || inst_pc !== 32'h40 || Instruction === 32'hDEAD_BEEF)
            begin errors++; $display("FAIL ro_deliver: seen %b got %h/%h exp pc 40, not deadbeef", seen, inst_pc, Instruction); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        auto_mem = 1'b0; use_const = 1'b0;
        cycle(1'b0, 1'b0, 32'h0);
        mem_ack = 1'b1; mem_rdata = word_of(32'h0);
        cycle(1'b0, 1'b1, 32'h200);
        checks++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL sim_redir_ack: got valid %b req %b exp 0 0", inst_valid, mem_req); end
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200)
            begin errors++; $display("FAIL sim_restart: got %b %b %h exp 0 1 200", inst_valid, mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = word_of(32'h200);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        mem_ack = 1'b1; mem_rdata = word_of(32'h204);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || mem_addr !== 32'h208)
            begin errors++; $display("FAIL sim_setup: got %b %h %h exp 1 200 208", inst_valid, inst_pc, mem_addr); end
        mem_ack = 1'b1; mem_rdata = word_of(32'h208);
        cycle(1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h204)
            begin errors++; $display("FAIL sim_pushpop: got %b %h exp 1 204", inst_valid, inst_pc); end
        cycle(1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h208)
            begin errors++; $display("FAIL sim_order: got %b %h exp 1 208", inst_valid, inst_pc); end
        cycle(1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b0)
            begin errors++; $display("FAIL sim_count: got valid %b exp 0 after two pops", inst_valid); end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        auto_mem = 1'b1; max_lat = 2; use_const = 1'b0;
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        n = req_addrs.size();
        for (int i = 0; i < 60 && req_addrs.size() < n + 2; i++) cycle(1'b1, 1'b0, 32'h0);
        checks++;
        if (req_addrs.size() < n + 2 || req_addrs[n] !== 32'hFFFF_FFFC || req_addrs[n+1] !== 32'h0)
            begin errors++; $display("FAIL wrap: got %0d requests exp fffffffc then 00000000", req_addrs.size() - n); end
        repeat (6) cycle(1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        auto_mem = 1'b0; use_const = 1'b0;
        cycle(1'b0, 1'b1, 32'h80);
        cycle(1'b0, 1'b0, 32'h0);
        mem_ack = 1'b1; mem_rdata = word_of(32'h80);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h80 || mem_req !== 1'b1 || mem_addr !== 32'h84)
            begin errors++; $display("FAIL rm_setup: got %b %h %b %h exp 1 80 1 84", inst_valid, inst_pc, mem_req, mem_addr); end
        ResetPC = 1'b1; mem_ack = 1'b1; mem_rdata = word_of(32'h84);
        redirect = 1'b1; redirect_pc = 32'h300; inst_ready = 1'b1;
        @(posedge CLK);
        #1;
        ResetPC = 1'b0; mem_ack = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
        model_init();
        checks++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b0 || Instruction !== NOP || inst_pc !== 32'h0)
            begin errors++; $display("FAIL rm_reset: got %b %b %h %h exp 0 0 00000013 0", mem_req, inst_valid, Instruction, inst_pc); end
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC)
            begin errors++; $display("FAIL rm_restart: got %b/%h exp 1/%h", mem_req, mem_addr, RESET_PC); end
    endtask

    task automatic test_random();
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        do_reset();
        auto_mem = 1'b1; max_lat = 3; use_const = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 99) < 60);
            rd  = ($urandom_range(0, 99) < 4);
            rpc = $urandom;
            cycle(rdy, rd, rpc);
        end
        checks++;
        if (m_pops < 200)
            begin errors++; $display("FAIL rand_progress: got %0d deliveries exp at least 200", m_pops); end
    endtask

    initial begin
        ResetPC = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; inst_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        auto_mem = 1'b0; max_lat = 0; lat_left = 0; use_const = 1'b0; const_word = 32'h0;
        model_init();
        test_reset();
        test_first_fetch_and_backpressure();
        test_redirect_idle();
        test_redirect_outstanding();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
